// File: rtl/pipeline_controller.sv
// Hazard/stall controller for a 5-stage in-order pipeline: stage enables, bubble flushes and operand forwarding.
// Enables/flushes are combinational from state and inputs; state, fwd_a/fwd_b and stall_count update on posedge clk.
module pipeline_controller #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_RegDest,
    input  logic        mem_RegWrite,
    input  logic [4:0]  mem_RegDest,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        flush_decode,
    output logic        flush_execute,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10,
        FLUSH      = 2'b11
    } state_t;

    localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

    state_t      r_state, w_next;
    state_t      r_pre, w_pre_next;
    state_t      w_rules;
    logic [1:0]  r_bub, w_bub_next;
    logic [4:0]  w_en;
    logic        w_flush_d, w_flush_e;
    logic        w_mem_stall, w_hold, w_load_use;
    logic [1:0]  r_fwd_a, r_fwd_b;
    logic [15:0] r_stall_cnt;

    assign w_mem_stall = mem_req & ~mem_ready;
    // Once in MEM_WAIT the pending access is outstanding until mem_ready, whatever mem_req does.
    assign w_hold      = w_mem_stall | ((r_state == MEM_WAIT) & ~mem_ready);
    assign w_load_use  = ex_MemRead & (ex_RegDest != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_RegDest)) |
                          (id_uses_rs2 & (id_rs2 == ex_RegDest)));
    // On the ready cycle the state that was interrupted decides the outcome.
    assign w_rules     = (r_state == MEM_WAIT) ? r_pre : r_state;

    always_comb begin
        w_next     = r_state;
        w_pre_next = r_pre;
        w_bub_next = r_bub;
        w_en       = 5'b11111;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        if (w_hold) begin
            w_en   = 5'b00000;
            w_next = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_pre_next = r_state;
            end
        end else if (branch_taken) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
            w_bub_next = 2'd0;
            w_next     = FLUSH;
        end else begin
            case (w_rules)
                RUN: begin
                    w_next = RUN;
                    if (w_load_use) begin
                        w_en       = 5'b00111;
                        w_flush_e  = 1'b1;
                        w_bub_next = BUB_INIT;
                        w_next     = (LOAD_BUBBLES > 1) ? LOAD_STALL : RUN;
                    end
                end
                LOAD_STALL: begin
                    w_en      = 5'b00111;
                    w_flush_e = 1'b1;
                    if (r_bub <= 2'd1) begin
                        w_bub_next = 2'd0;
                        w_next     = RUN;
                    end else begin
                        w_bub_next = r_bub - 2'd1;
                        w_next     = LOAD_STALL;
                    end
                end
                FLUSH: begin
                    w_flush_d = 1'b1;
                    w_next    = RUN;
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pre   <= RUN;
            r_bub   <= 2'd0;
        end else begin
            r_state <= w_next;
            r_pre   <= w_pre_next;
            r_bub   <= w_bub_next;
        end
    end

    assign fetch_en      = w_en[4] & ~rst;
    assign decode_en     = w_en[3] & ~rst;
    assign execute_en    = w_en[2] & ~rst;
    assign mem_en        = w_en[1] & ~rst;
    assign wb_en         = w_en[0] & ~rst;
    assign flush_decode  = w_flush_d & ~rst;
    assign flush_execute = w_flush_e & ~rst;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (ex_RegWrite && (ex_RegDest != 5'd0) && (ex_RegDest == rs)) begin
            return 2'b01;
        end else if (mem_RegWrite && (mem_RegDest != 5'd0) && (mem_RegDest == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else if (execute_en) begin
            r_fwd_a <= flush_execute ? 2'b00 : fwd_sel(id_rs1);
            r_fwd_b <= flush_execute ? 2'b00 : fwd_sel(id_rs2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!fetch_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign state       = r_state;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: vector table on a LOAD_BUBBLES=1 instance,
// hand-written multi-cycle sequences on a LOAD_BUBBLES=3 instance.
module tb_pipeline_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_RegDest = '0, mem_RegDest = '0;
    logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_RegWrite = 0, ex_MemRead = 0;
    logic       mem_RegWrite = 0, branch_taken = 0, mem_req = 0, mem_ready = 0;

    logic        d1_fe, d1_de, d1_ee, d1_me, d1_we, d1_fd, d1_fx;
    logic [1:0]  d1_fa, d1_fb, d1_st;
    logic [15:0] d1_sc;
    logic        d3_fe, d3_de, d3_ee, d3_me, d3_we, d3_fd, d3_fx;
    logic [1:0]  d3_fa, d3_fb, d3_st;
    logic [15:0] d3_sc;

    pipeline_controller #(.LOAD_BUBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_RegDest(ex_RegDest),
        .mem_RegWrite(mem_RegWrite), .mem_RegDest(mem_RegDest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .fetch_en(d1_fe), .decode_en(d1_de), .execute_en(d1_ee), .mem_en(d1_me), .wb_en(d1_we),
        .flush_decode(d1_fd), .flush_execute(d1_fx), .fwd_a(d1_fa), .fwd_b(d1_fb),
        .state(d1_st), .stall_count(d1_sc));

    pipeline_controller #(.LOAD_BUBBLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_RegDest(ex_RegDest),
        .mem_RegWrite(mem_RegWrite), .mem_RegDest(mem_RegDest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .fetch_en(d3_fe), .decode_en(d3_de), .execute_en(d3_ee), .mem_en(d3_me), .wb_en(d3_we),
        .flush_decode(d3_fd), .flush_execute(d3_fx), .fwd_a(d3_fa), .fwd_b(d3_fb),
        .state(d3_st), .stall_count(d3_sc));

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2, exw, exr;
        logic [4:0]  exd;
        logic        mw;
        logic [4:0]  md;
        logic        br, mreq, mrdy;
        logic [4:0]  en;
        logic        fd, fx;
        logic [1:0]  st, fa, fb;
        logic [15:0] sc;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
        input logic exw, input logic exr, input logic [4:0] exd, input logic mw,
        input logic [4:0] md, input logic br, input logic mreq, input logic mrdy,
        input logic [4:0] en, input logic fd, input logic fx, input logic [1:0] st,
        input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] sc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exw = exw; v.exr = exr;
        v.exd = exd; v.mw = mw; v.md = md; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        v.en = en; v.fd = fd; v.fx = fx; v.st = st; v.fa = fa; v.fb = fb; v.sc = sc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_RegWrite = v.exw; ex_MemRead = v.exr; ex_RegDest = v.exd;
        mem_RegWrite = v.mw; mem_RegDest = v.md;
        branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic idle();
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b0,0,0,0,0,0,0));
    endtask

    task automatic hazard();
        idle();
        ex_MemRead = 1; ex_RegDest = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [4:0] en, input logic fd, input logic fx,
                        input logic [1:0] st, input logic [15:0] sc);
        chk({name, ".en"}, {27'd0, d3_fe, d3_de, d3_ee, d3_me, d3_we}, {27'd0, en});
        chk({name, ".flush"}, {30'd0, d3_fd, d3_fx}, {30'd0, fd, fx});
        chk({name, ".state"}, {30'd0, d3_st}, {30'd0, st});
        chk({name, ".stall_count"}, {16'd0, d3_sc}, {16'd0, sc});
    endtask

    // Reset pulse inside the low clock phase, leaving idle inputs applied.
    task automatic pulse_reset();
        idle();
        rst = 1;
        #2 rst = 0;
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0,0,0,0);
        vecs[1]  = mk(5,0,1,0,0,1,5,0,0,0,0,0, 5'b00111,0,1,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0,0,0,1);
        vecs[3]  = mk(7,0,0,0,1,0,7,1,7,0,0,0, 5'b11111,0,0,0,0,0,1);
        vecs[4]  = mk(3,0,0,0,1,0,0,1,3,0,0,0, 5'b11111,0,0,0,1,0,1);
        vecs[5]  = mk(0,0,0,0,1,0,0,1,0,0,0,0, 5'b11111,0,0,0,2,0,1);
        vecs[6]  = mk(1,9,0,0,0,0,0,1,9,0,0,0, 5'b11111,0,0,0,0,0,1);
        vecs[7]  = mk(5,0,1,0,0,1,5,0,0,1,0,0, 5'b11111,1,1,0,0,2,1);
        vecs[8]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,1,0,3,0,0,1);
        vecs[9]  = mk(4,0,0,0,1,0,4,0,0,0,0,0, 5'b11111,0,0,0,0,0,1);
        vecs[10] = mk(0,0,0,0,0,0,0,0,0,0,1,0, 5'b00000,0,0,0,1,0,1);
        vecs[11] = mk(0,0,0,0,0,0,0,0,0,0,1,0, 5'b00000,0,0,2,1,0,2);
        vecs[12] = mk(0,0,0,0,0,0,0,0,0,0,1,0, 5'b00000,0,0,2,1,0,3);
        vecs[13] = mk(0,0,0,0,0,0,0,0,0,0,1,0, 5'b00000,0,0,2,1,0,4);
        vecs[14] = mk(0,0,0,0,0,0,0,0,0,0,1,1, 5'b11111,0,0,2,1,0,5);
        vecs[15] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0,0,0,5);
        vecs[16] = mk(0,0,0,0,0,0,0,0,0,1,1,0, 5'b00000,0,0,0,0,0,5);
        vecs[17] = mk(0,0,0,0,0,0,0,0,0,1,1,1, 5'b11111,1,1,2,0,0,6);
        vecs[18] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,1,0,3,0,0,6);
        vecs[19] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0,0,0,6);
        vecs[20] = mk(0,0,1,0,0,1,0,0,0,0,0,0, 5'b11111,0,0,0,0,0,6);
        vecs[21] = mk(0,6,0,1,0,1,6,0,0,0,0,0, 5'b00111,0,1,0,0,0,6);
        vecs[22] = mk(0,6,0,0,0,1,6,0,0,0,0,0, 5'b11111,0,0,0,0,0,7);

        // Reset state, observed before the first clock edge.
        idle();
        #3;
        chk("rst.en1", {27'd0, d1_fe, d1_de, d1_ee, d1_me, d1_we}, 32'd0);
        chk("rst.flush1", {30'd0, d1_fd, d1_fx}, 32'd0);
        chk("rst.state1", {30'd0, d1_st}, 32'd0);
        chk("rst.fwd1", {28'd0, d1_fa, d1_fb}, 32'd0);
        chk("rst.sc1", {16'd0, d1_sc}, 32'd0);
        chk3("rst.d3", 5'b00000, 0, 0, 2'd0, 16'd0);

        @(negedge clk);
        rst = 0;
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d.en", i), {27'd0, d1_fe, d1_de, d1_ee, d1_me, d1_we}, {27'd0, vecs[i].en});
            chk($sformatf("v%0d.flush", i), {30'd0, d1_fd, d1_fx}, {30'd0, vecs[i].fd, vecs[i].fx});
            chk($sformatf("v%0d.state", i), {30'd0, d1_st}, {30'd0, vecs[i].st});
            chk($sformatf("v%0d.fwd_a", i), {30'd0, d1_fa}, {30'd0, vecs[i].fa});
            chk($sformatf("v%0d.fwd_b", i), {30'd0, d1_fb}, {30'd0, vecs[i].fb});
            chk($sformatf("v%0d.stall_count", i), {16'd0, d1_sc}, {16'd0, vecs[i].sc});
            @(negedge clk);
        end

        // Three-bubble load-use hazard.
        pulse_reset();
        hazard();
        #1 chk3("lb3.c1", 5'b00111, 0, 1, 2'd0, 16'd0);
        @(negedge clk); idle();
        #1 chk3("lb3.c2", 5'b00111, 0, 1, 2'd1, 16'd1);
        @(negedge clk);
        #1 chk3("lb3.c3", 5'b00111, 0, 1, 2'd1, 16'd2);
        @(negedge clk);
        #1 chk3("lb3.c4", 5'b11111, 0, 0, 2'd0, 16'd3);

        // Memory stall in the middle of the bubbles: counter holds, resumes on ready.
        @(negedge clk);
        pulse_reset();
        hazard();
        #1 chk3("lsmw.c1", 5'b00111, 0, 1, 2'd0, 16'd0);
        @(negedge clk); idle(); mem_req = 1;
        #1 chk3("lsmw.c2", 5'b00000, 0, 0, 2'd1, 16'd1);
        @(negedge clk);
        #1 chk3("lsmw.c3", 5'b00000, 0, 0, 2'd2, 16'd2);
        @(negedge clk); mem_ready = 1;
        #1 chk3("lsmw.c4", 5'b00111, 0, 1, 2'd2, 16'd3);
        @(negedge clk); idle();
        #1 chk3("lsmw.c5", 5'b00111, 0, 1, 2'd1, 16'd4);
        @(negedge clk);
        #1 chk3("lsmw.c6", 5'b11111, 0, 0, 2'd0, 16'd5);

        // Asynchronous reset while in MEM_WAIT clears forwarding and counters.
        @(negedge clk);
        pulse_reset();
        ex_RegWrite = 1; ex_RegDest = 8; id_rs1 = 8;
        #1 chk3("rmw.c1", 5'b11111, 0, 0, 2'd0, 16'd0);
        @(negedge clk); idle(); mem_req = 1;
        #1 chk("rmw.fwd_a", {30'd0, d3_fa}, 32'd1);
        @(negedge clk);
        #1 chk3("rmw.c3", 5'b00000, 0, 0, 2'd2, 16'd1);
        #1 rst = 1;
        #1 chk3("rmw.async", 5'b00000, 0, 0, 2'd0, 16'd0);
        chk("rmw.async.fwd", {28'd0, d3_fa, d3_fb}, 32'd0);
        @(negedge clk); rst = 0; idle();
        #1 chk3("rmw.after", 5'b11111, 0, 0, 2'd0, 16'd0);

        // Asynchronous reset during LOAD_STALL abandons remaining bubbles.
        @(negedge clk);
        pulse_reset();
        hazard();
        @(negedge clk); idle();
        #1 chk3("rls.c2", 5'b00111, 0, 1, 2'd1, 16'd1);
        #1 rst = 1;
        #1 chk3("rls.async", 5'b00000, 0, 0, 2'd0, 16'd0);
        @(negedge clk); rst = 0;
        #1 chk3("rls.after1", 5'b11111, 0, 0, 2'd0, 16'd0);
        @(negedge clk);
        #1 chk3("rls.after2", 5'b11111, 0, 0, 2'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter LOAD_BUBBLES, default 1, legal range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5  source register indices of the instruction in decode.
- id_uses_rs1, id_uses_rs2  in  1  the decode instruction reads rs1 / rs2.
- ex_RegWrite, ex_MemRead  in  1  control bits of the instruction in execute.
- ex_RegDest  in  5  destination of the instruction in execute.
- mem_RegWrite  in  1  control bit of the instruction in memory stage.
- mem_RegDest  in  5  destination of the instruction in memory stage.
- branch_taken  in  1  execute resolved a taken branch or jump this cycle.
- mem_req, mem_ready  in  1  data-memory access pending / access completes this cycle.
- fetch_en, decode_en, execute_en, mem_en, wb_en  out  1  per-stage enables.
- flush_decode, flush_execute  out  1  load a bubble into decode / execute.
- fwd_a, fwd_b  out  2  execute operand source: 00 regfile, 01 execute result, 10 memory result.
- state  out  2  current FSM state.
- stall_count  out  16  saturating count of fetch-stall cycles.

Function
REQ-003 SHALL implement states RUN=00, LOAD_STALL=01, MEM_WAIT=10, FLUSH=11; state SHALL be registered; stage enables and flushes SHALL be combinational from state and inputs.
REQ-004 Event definitions:
- mem_stall = mem_req & !mem_ready.
- load_use = ex_MemRead & ex_RegDest!=0 & ((id_uses_rs1 & id_rs1==ex_RegDest) | (id_uses_rs2 & id_rs2==ex_RegDest)).
REQ-005 Event priority in any state: mem_stall > branch_taken > load_use.
REQ-006 mem_stall SHALL drive all five enables 0 and both flushes 0; next state MEM_WAIT; a bubble counter in progress SHALL hold its value.
REQ-007 In MEM_WAIT:
- while mem_ready=0: remain in MEM_WAIT with all enables 0.
- cycle mem_ready=1: evaluate the pre-stall state's rules in that same cycle and take the resulting next state.
REQ-008 branch_taken in RUN or LOAD_STALL (no mem_stall):
- all enables 1, flush_decode=1, flush_execute=1.
- next state FLUSH; any pending load bubbles are cancelled.
REQ-009 FLUSH SHALL last exactly one cycle: all enables 1, flush_decode=1, flush_execute=0, then RUN, unless REQ-005 selects another event.
REQ-010 load_use in RUN (no higher-priority event):
- fetch_en=0, decode_en=0, flush_execute=1, execute/mem/wb enables 1.
- bubble counter loaded with LOAD_BUBBLES-1; next state LOAD_STALL if LOAD_BUBBLES>1, else RUN.
REQ-011 LOAD_STALL SHALL repeat the outputs of REQ-010 and decrement the counter each cycle, returning to RUN in the cycle after the counter reaches 0; total bubbles per hazard = LOAD_BUBBLES.
REQ-012 RUN with no event: all enables 1, both flushes 0.
REQ-013 fwd_a/fwd_b SHALL be registered, updated only when execute_en=1; operand rsN selection:
- flush_execute=1 loads 00.
- else 01 if ex_RegWrite & ex_RegDest!=0 & ex_RegDest==id_rsN.
- else 10 if mem_RegWrite & mem_RegDest!=0 & mem_RegDest==id_rsN.
- else 00.
REQ-014 Register x0 SHALL never match for hazard or forwarding purposes.
REQ-015 stall_count SHALL increment by 1 on each posedge where fetch_en=0 and rst=0, and saturate at 16'hFFFF.

Reset
REQ-016 rst=1 SHALL immediately, independent of clk:
- set state=RUN, bubble counter=0, fwd_a=fwd_b=00, stall_count=0.
- force all enables 0 and both flushes 0.
REQ-017 Reset asserted mid-stall or mid-flush SHALL abandon the operation; the first cycle after deassertion SHALL follow RUN rules.

Verification
REQ-018 Load-use, LOAD_BUBBLES=1: ex_MemRead=1, ex_RegDest=5, id_rs1=5, id_uses_rs1=1 -> one cycle fetch_en=0, decode_en=0, flush_execute=1; stall_count=1; then RUN.
REQ-019 LOAD_BUBBLES=3, same hazard -> 3 consecutive bubble cycles with state=01 for cycles 2..3; stall_count=3.
REQ-020 branch_taken=1 together with load_use -> flush_decode=flush_execute=1, no fetch stall; next cycle state=11, flush_decode=1; then RUN.
REQ-021 mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, state=10, stall_count=4; enables return to 1 on the ready cycle.
REQ-022 Forwarding: ex_RegWrite=1, ex_RegDest=7, mem_RegWrite=1, mem_RegDest=7, id_rs1=7; then id_rs2=0 with ex_RegDest=0 -> fwd_a=01 next cycle (execute priority); fwd_b=00 (x0 excluded).
REQ-023 Reset asserted in MEM_WAIT and LOAD_STALL -> outputs cleared asynchronously, stall_count=0, state=00 after release.
